// File: rtl/key_filter_pkg.sv
// key_filter_pkg: shared types and default constants for the push-button
// conditioning block (key_filter / key_filter_ch).
//   key_state_t      per-channel debounce FSM state
//   *_DEF constants  debounce / auto-repeat limits for a 100 MHz clock
//   cnt_width()      bit width of a counter that must reach a given max value
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } key_state_t;

  localparam int unsigned CNT_MAX_DEF     = 1_999_999;   // 20 ms
  localparam int unsigned RPT_DLY_MAX_DEF = 49_999_999;  // 500 ms
  localparam int unsigned RPT_PER_MAX_DEF = 9_999_999;   // 100 ms

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// key_filter_ch: one push-button channel.
//   2-FF synchroniser, debounce FSM, registered 1-cycle press/release pulses,
//   toggle level flipped on every genuine press.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat key_press while held).
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst_p   in   synchronous active-high reset
//   key_in      in   raw asynchronous pin
//   key_level   out  debounced level, 1 = pressed
//   key_press   out  1-cycle pulse on press (and each auto-repeat)
//   key_release out  1-cycle pulse on release
//   key_toggle  out  flips on every genuine press
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter logic        KEY_ACTIVE  = 1'b0,
  parameter int unsigned CNT_MAX     = CNT_MAX_DEF
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned RPT_DLY_MAX = RPT_DLY_MAX_DEF,
  parameter int unsigned RPT_PER_MAX = RPT_PER_MAX_DEF
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst_p,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  localparam int unsigned CW = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1, sync2;
  logic          s;
  key_state_t    state;
  logic [CW-1:0] cnt;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RW = cnt_width((RPT_DLY_MAX > RPT_PER_MAX) ? RPT_DLY_MAX : RPT_PER_MAX);
  localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY_MAX);
  localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER_MAX);
  localparam logic [RW-1:0] RPT_ONE  = RW'(1);

  logic [RW-1:0] rpt;
  logic          rpt_period;  // 0: waiting initial delay, 1: periodic phase
`endif

  always_comb s = (sync2 == KEY_ACTIVE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      sync1       <= ~KEY_ACTIVE;
      sync2       <= ~KEY_ACTIVE;
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_toggle  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt         <= '0;
      rpt_period  <= 1'b0;
`endif
    end else begin
      sync1       <= key_in;
      sync2       <= sync1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= HELD;
            cnt        <= '0;
            key_level  <= 1'b1;
            key_press  <= 1'b1;
            key_toggle <= ~key_toggle;
`ifdef KEY_AUTOREPEAT_EN
            rpt        <= '0;
            rpt_period <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state <= REL_CHK;
            cnt   <= '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rpt == (rpt_period ? PER_LAST : DLY_LAST)) begin
            key_press  <= 1'b1;
            rpt        <= '0;
            rpt_period <= 1'b1;
          end else begin
            rpt <= rpt + RPT_ONE;
          end
`endif
        end
        REL_CHK: begin
          // A bounce back to pressed resumes HELD with the repeat timer untouched.
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_filter.sv
// key_filter: conditions the raw push-buttons (set_time, set_hour, set_min)
// before the timekeeping block; one key_filter_ch per key.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat while a key is held).
// Ports:
//   sys_clk     in   1        system clock, rising edge
//   sys_rst_p   in   1        synchronous active-high reset
//   key_in      in   KEY_NUM  raw asynchronous button pins
//   key_level   out  KEY_NUM  debounced level, 1 = pressed
//   key_press   out  KEY_NUM  1-cycle pulse on press (and each auto-repeat)
//   key_release out  KEY_NUM  1-cycle pulse on release
//   key_toggle  out  KEY_NUM  flips on every genuine press
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned KEY_NUM     = 3,
  parameter logic        KEY_ACTIVE  = 1'b0,
  parameter int unsigned CNT_MAX     = CNT_MAX_DEF,
  parameter int unsigned RPT_DLY_MAX = RPT_DLY_MAX_DEF,
  parameter int unsigned RPT_PER_MAX = RPT_PER_MAX_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_p,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_toggle
);

  // Counter widths derive from these limits, so zero is not a usable value.
  if (KEY_NUM < 1 || CNT_MAX < 1 || RPT_DLY_MAX < 1 || RPT_PER_MAX < 1) begin : g_param_check
    $error("key_filter: KEY_NUM and all count limits must be at least 1");
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_filter_ch #(
      .KEY_ACTIVE  (KEY_ACTIVE),
      .CNT_MAX     (CNT_MAX)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .RPT_DLY_MAX (RPT_DLY_MAX),
      .RPT_PER_MAX (RPT_PER_MAX)
`endif
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_p   (sys_rst_p),
      .key_in      (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_toggle  (key_toggle[i])
    );
  end

endmodule
